ex_mem_pipe_elastic: RTL and testbench
======================================

// Module: ex_mem_pipe_elastic
// PURPOSE
//  Parametrised EX->MEM pipeline stage register with valid/ready flow control, a flush input and an optional skid slot.
//  Sits between the execute and memory stages.
//  Carries the ALU result, the store data, the destination register and the control bits.
//  Lets the hazard unit stall or squash the stage without losing or duplicating an instruction.
//  Ctrl outputs are forced to zero whenever the stage holds a bubble.
// PARAMETERS
//  DATA_W      32  width of ALU result and store data
//  REG_ADDR_W  5   destination register address width
//  CTRL_W      3   control bits; bit0 RegWrite, bit1 MemtoReg, bit2 MemWrite
//  SKID        1   1 = 2-entry skid buffer (registered in_ready); 0 = single register (combinational in_ready)
// PORTS
//  clk        in   1           clock, rising edge
//  Rst        in   1           asynchronous active-low reset
//  flush      in   1           synchronous squash of stage contents and of the current input
//  in_valid   in   1           EX presents a valid instruction
//  in_ready   out  1           stage accepts input this cycle
//  aluout_in  in   DATA_W      ALU result from EX
//  wdata_in   in   DATA_W      store data from EX
//  wreg_in    in   REG_ADDR_W  destination register from EX
//  ctrl_in    in   CTRL_W      control bits from EX
//  out_valid  out  1           stage holds a valid instruction for MEM
//  out_ready  in   1           MEM consumes the output this cycle
//  aluout_out out  DATA_W      registered ALU result
//  wdata_out  out  DATA_W      registered store data
//  wreg_out   out  REG_ADDR_W  registered destination register
//  ctrl_out   out  CTRL_W      registered ctrl AND {CTRL_W{out_valid}}
// BEHAVIOUR
//  - Reset (Rst=0, async): state EMPTY; all payload regs 0; out_valid=0; ctrl_out=0; in_ready=1 once Rst deasserts.
//  - Transfer rules: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
//  - Latency is 1 cycle, input to output; sustained throughput is 1 per cycle.
//  - SKID=1 state machine:
//      EMPTY: in_fire -> HALF, main<=in.
//      HALF:  in_fire & out_fire -> HALF, main<=in.
//             in_fire & !out_fire -> FULL, skid<=in.
//             !in_fire & out_fire -> EMPTY.
//      FULL:  in_ready=0; out_fire -> HALF, main<=skid.
//  - SKID=1: in_ready is a flop output, 1 iff next state != FULL.
//  - SKID=0: states EMPTY/HALF only; in_ready = !out_valid | out_ready.
//  - out_valid = (state != EMPTY). Outputs always present the main slot; ordering is strictly FIFO.
//  - flush=1: highest priority; next state EMPTY, the skid slot is emptied, and in_fire that cycle is discarded.
//    Payload data regs may hold stale values; ctrl_out reads 0 from the next cycle.
//  - Flush concurrent with out_fire: MEM takes the current output that edge; the stage is EMPTY afterwards.
//  - Rst asserted mid-transfer: contents dropped immediately (async); no partial update.
//  - Payload is never modified while out_valid & !out_ready (stable-hold rule).
//  - No arithmetic; all fields pass through at full width.
// STRUCTURE
//  - Package pipe_pkg holds:
//      stage_state_t enum (EMPTY, HALF, FULL);
//      CTRL_REGWRITE/CTRL_MEMTOREG/CTRL_MEMWRITE bit indices;
//      a packed ex_mem_payload_t {aluout, wdata, wreg, ctrl}.
//  - Sub-module pipe_slot: a load-enabled payload register with async active-low reset.
//    Instantiated as main and, when SKID=1, as skid (generate).
//  - FSM and handshake logic live in ex_mem_pipe_elastic.
// TESTING
//  1. Reset: Rst=0 with random inputs -> out_valid=0, ctrl_out=0, aluout_out=0.
//     Release Rst -> in_ready=1.
//  2. Streaming: out_ready=1, send aluout 1..8 back-to-back -> 1..8 appear one cycle later, every cycle, no gaps.
//  3. Backpressure (SKID=1): push A=0x11, B=0x22 with out_ready=0 -> in_ready=0 after B, out=A held.
//     Raise out_ready -> A then B, in order, nothing lost.
//  4. Flush: stage FULL (A, B) with in_valid=1 (C), pulse flush -> next cycle out_valid=0, ctrl_out=0.
//     C is not delivered later.
//  5. Bubble gating: ctrl_in=3'b111 with in_valid=0 -> ctrl_out stays 3'b000.
//     A valid MemWrite (ctrl_in=3'b100) -> ctrl_out=3'b100 for exactly one out_fire.
//  6. SKID=0 build: out_ready=0, out_valid=1 -> in_ready=0 combinationally.
//     out_ready=1 in the same cycle -> in_ready=1 and the new data is captured.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared types for the EX->MEM elastic pipeline stage.
// Slot states, control bit positions and the payload layout.
package pipe_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        HALF  = 2'd1,
        FULL  = 2'd2
    } stage_state_t;

    localparam int CTRL_REGWRITE = 0;
    localparam int CTRL_MEMTOREG = 1;
    localparam int CTRL_MEMWRITE = 2;

    localparam int PL_DATA_W     = 32;
    localparam int PL_REG_ADDR_W = 5;
    localparam int PL_CTRL_W     = 3;

    typedef struct packed {
        logic [PL_DATA_W-1:0]     aluout;
        logic [PL_DATA_W-1:0]     wdata;
        logic [PL_REG_ADDR_W-1:0] wreg;
        logic [PL_CTRL_W-1:0]     ctrl;
    } ex_mem_payload_t;

endpackage

// File: rtl/pipe_slot.sv
// Load-enabled payload register for one pipeline slot.
// Clears to zero on asynchronous active-low reset.
module pipe_slot #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         Rst,
    input  logic         ld,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    // hold unless loaded; reset clears contents
    always_ff @(posedge clk or negedge Rst) begin
        if (!Rst)
            q <= '0;
        else if (ld)
            q <= d;
    end

endmodule

// File: rtl/ex_mem_pipe_elastic.sv
// EX->MEM stage register with valid/ready flow control and flush.
// Optional skid slot gives a registered in_ready.
module ex_mem_pipe_elastic
    import pipe_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5,
    parameter int CTRL_W     = 3,
    parameter int SKID       = 1
) (
    input  logic                  clk,
    input  logic                  Rst,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_W-1:0]     aluout_in,
    input  logic [DATA_W-1:0]     wdata_in,
    input  logic [REG_ADDR_W-1:0] wreg_in,
    input  logic [CTRL_W-1:0]     ctrl_in,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_W-1:0]     aluout_out,
    output logic [DATA_W-1:0]     wdata_out,
    output logic [REG_ADDR_W-1:0] wreg_out,
    output logic [CTRL_W-1:0]     ctrl_out
);

    localparam int PW = 2 * DATA_W + REG_ADDR_W + CTRL_W;

    stage_state_t    state_q;
    stage_state_t    state_d;
    logic            in_fire;
    logic            out_fire;
    logic            main_ld;
    logic            skid_ld;
    logic            main_sel_skid;
    logic [PW-1:0]   in_pl;
    logic [PW-1:0]   main_d;
    logic [PW-1:0]   main_q;
    logic [PW-1:0]   skid_q;
    logic [CTRL_W-1:0] ctrl_q;

    assign in_pl    = {aluout_in, wdata_in, wreg_in, ctrl_in};
    assign in_fire  = in_valid & in_ready;
    assign out_fire = out_valid & out_ready;
    assign out_valid = (state_q != EMPTY);

    // next state and slot load enables; flush overrides everything
    always_comb begin
        state_d       = state_q;
        main_ld       = 1'b0;
        skid_ld       = 1'b0;
        main_sel_skid = 1'b0;
        if (flush) begin
            state_d = EMPTY;
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (in_fire) begin
                        state_d = HALF;
                        main_ld = 1'b1;
                    end
                end
                HALF: begin
                    if (in_fire && out_fire) begin
                        main_ld = 1'b1;
                    end else if (in_fire && SKID != 0) begin
                        state_d = FULL;
                        skid_ld = 1'b1;
                    end else if (out_fire) begin
                        state_d = EMPTY;
                    end
                end
                FULL: begin
                    if (out_fire) begin
                        state_d       = HALF;
                        main_ld       = 1'b1;
                        main_sel_skid = 1'b1;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    // state register
    always_ff @(posedge clk or negedge Rst) begin
        if (!Rst)
            state_q <= EMPTY;
        else
            state_q <= state_d;
    end

    assign main_d = main_sel_skid ? skid_q : in_pl;

    pipe_slot #(.W(PW)) u_main (
        .clk (clk),
        .Rst (Rst),
        .ld  (main_ld),
        .d   (main_d),
        .q   (main_q)
    );

    generate
        if (SKID != 0) begin : g_skid
            logic rdy_q;

            pipe_slot #(.W(PW)) u_skid (
                .clk (clk),
                .Rst (Rst),
                .ld  (skid_ld),
                .d   (in_pl),
                .q   (skid_q)
            );

            // registered ready: open unless the stage will be full
            always_ff @(posedge clk or negedge Rst) begin
                if (!Rst)
                    rdy_q <= 1'b1;
                else
                    rdy_q <= (state_d != FULL);
            end

            assign in_ready = rdy_q;
        end else begin : g_noskid
            // skid_ld is constant zero here, so this slot reads as empty
            assign skid_q   = {PW{skid_ld}} & in_pl;
            assign in_ready = !out_valid | out_ready;
        end
    endgenerate

    assign {aluout_out, wdata_out, wreg_out, ctrl_q} = main_q;
    assign ctrl_out = ctrl_q & {CTRL_W{out_valid}};

endmodule

// File: tb/tb_ex_mem_pipe_elastic.sv
// Directed bench for ex_mem_pipe_elastic.
// Covers SKID=1 and SKID=0 builds side by side.
module tb_ex_mem_pipe_elastic;
    import pipe_pkg::*;

    logic        clk;
    logic        Rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] aluout_in;
    logic [31:0] wdata_in;
    logic [4:0]  wreg_in;
    logic [2:0]  ctrl_in;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] aluout_out;
    logic [31:0] wdata_out;
    logic [4:0]  wreg_out;
    logic [2:0]  ctrl_out;

    logic        in_valid0;
    logic        in_ready0;
    logic [31:0] aluout_in0;
    logic        out_valid0;
    logic        out_ready0;
    logic [31:0] aluout_out0;
    logic [31:0] wdata_out0;
    logic [4:0]  wreg_out0;
    logic [2:0]  ctrl_out0;

    int n_assert;
    int n_fail;

    ex_mem_pipe_elastic #(.SKID(1)) dut (
        .clk        (clk),
        .Rst        (Rst),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .aluout_in  (aluout_in),
        .wdata_in   (wdata_in),
        .wreg_in    (wreg_in),
        .ctrl_in    (ctrl_in),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .aluout_out (aluout_out),
        .wdata_out  (wdata_out),
        .wreg_out   (wreg_out),
        .ctrl_out   (ctrl_out)
    );

    ex_mem_pipe_elastic #(.SKID(0)) dut0 (
        .clk        (clk),
        .Rst        (Rst),
        .flush      (flush),
        .in_valid   (in_valid0),
        .in_ready   (in_ready0),
        .aluout_in  (aluout_in0),
        .wdata_in   (wdata_in),
        .wreg_in    (wreg_in),
        .ctrl_in    (ctrl_in),
        .out_valid  (out_valid0),
        .out_ready  (out_ready0),
        .aluout_out (aluout_out0),
        .wdata_out  (wdata_out0),
        .wreg_out   (wreg_out0),
        .ctrl_out   (ctrl_out0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_assert   = 0;
        n_fail     = 0;
        Rst        = 1'b1;
        flush      = 1'b0;
        in_valid   = 1'b1;
        out_ready  = 1'b1;
        aluout_in  = $urandom;
        wdata_in   = $urandom;
        wreg_in    = 5'($urandom);
        ctrl_in    = 3'b111;
        in_valid0  = 1'b1;
        out_ready0 = 1'b1;
        aluout_in0 = $urandom;
        #2;
        Rst = 1'b0;

        // reset with random, valid-looking inputs
        repeat (2) cyc();
        aluout_in = $urandom;
        @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_ctrl_out", 32'(ctrl_out), 32'd0);
        chk("rst_aluout", aluout_out, 32'd0);
        chk("rst_out_valid0", 32'(out_valid0), 32'd0);

        cyc();
        Rst       = 1'b1;
        in_valid  = 1'b0;
        in_valid0 = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_in_ready0", 32'(in_ready0), 32'd1);

        // streaming 1..8, one per cycle
        ctrl_in = 3'b001;
        for (int i = 1; i <= 8; i++) begin
            cyc();
            in_valid  = 1'b1;
            aluout_in = 32'(i);
            wdata_in  = 32'(i + 100);
            wreg_in   = 5'(i);
            if (i >= 2) begin
                @(negedge clk);
                chk("stream_valid", 32'(out_valid), 32'd1);
                chk("stream_alu", aluout_out, 32'(i - 1));
                chk("stream_wdata", wdata_out, 32'(i + 99));
                chk("stream_rdy", 32'(in_ready), 32'd1);
            end
        end
        cyc();
        in_valid = 1'b0;
        @(negedge clk);
        chk("stream_last_alu", aluout_out, 32'd8);
        chk("stream_last_wreg", 32'(wreg_out), 32'd8);
        cyc();
        @(negedge clk);
        chk("stream_drained", 32'(out_valid), 32'd0);

        // backpressure into the skid slot
        cyc();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        aluout_in = 32'h11;
        cyc();
        aluout_in = 32'h22;
        @(negedge clk);
        chk("bp_rdy_a", 32'(in_ready), 32'd1);
        chk("bp_out_a", aluout_out, 32'h11);
        cyc();
        aluout_in = 32'h33;
        @(negedge clk);
        chk("bp_rdy_full", 32'(in_ready), 32'd0);
        chk("bp_hold_a", aluout_out, 32'h11);
        cyc();
        @(negedge clk);
        chk("bp_hold_a2", aluout_out, 32'h11);
        chk("bp_valid", 32'(out_valid), 32'd1);
        cyc();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_drain_a", aluout_out, 32'h11);
        cyc();
        @(negedge clk);
        chk("bp_drain_b", aluout_out, 32'h22);
        chk("bp_rdy_back", 32'(in_ready), 32'd1);
        cyc();
        @(negedge clk);
        chk("bp_empty", 32'(out_valid), 32'd0);

        // flush a full stage while C is offered
        out_ready = 1'b0;
        in_valid  = 1'b1;
        ctrl_in   = 3'b001;
        aluout_in = 32'hA1;
        cyc();
        aluout_in = 32'hB2;
        cyc();
        aluout_in = 32'hC3;
        flush     = 1'b1;
        @(negedge clk);
        chk("fl_full_rdy", 32'(in_ready), 32'd0);
        chk("fl_pre_ctrl", 32'(ctrl_out), 32'd1);
        cyc();
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        chk("fl_valid", 32'(out_valid), 32'd0);
        chk("fl_ctrl", 32'(ctrl_out), 32'd0);
        chk("fl_rdy", 32'(in_ready), 32'd1);
        repeat (3) cyc();
        @(negedge clk);
        chk("fl_no_c", 32'(out_valid), 32'd0);

        // flush discards a same-cycle accepted input
        cyc();
        in_valid  = 1'b1;
        aluout_in = 32'hD4;
        flush     = 1'b1;
        cyc();
        in_valid = 1'b0;
        flush    = 1'b0;
        @(negedge clk);
        chk("fl_in_drop", 32'(out_valid), 32'd0);

        // bubble gating of control bits
        cyc();
        in_valid = 1'b0;
        ctrl_in  = 3'b111;
        cyc();
        @(negedge clk);
        chk("bub_ctrl", 32'(ctrl_out), 32'd0);
        cyc();
        in_valid  = 1'b1;
        ctrl_in   = 3'b100;
        aluout_in = 32'h55;
        cyc();
        in_valid = 1'b0;
        ctrl_in  = 3'b111;
        @(negedge clk);
        chk("bub_memwr", 32'(ctrl_out[CTRL_MEMWRITE]), 32'd1);
        chk("bub_ctrl_one", 32'(ctrl_out), 32'b100);
        cyc();
        @(negedge clk);
        chk("bub_after", 32'(ctrl_out), 32'd0);

        // SKID=0: combinational ready
        in_valid0  = 1'b1;
        out_ready0 = 1'b0;
        aluout_in0 = 32'h61;
        cyc();
        aluout_in0 = 32'h62;
        @(negedge clk);
        chk("s0_valid", 32'(out_valid0), 32'd1);
        chk("s0_rdy_low", 32'(in_ready0), 32'd0);
        chk("s0_out_a", aluout_out0, 32'h61);
        cyc();
        @(negedge clk);
        chk("s0_hold", aluout_out0, 32'h61);
        out_ready0 = 1'b1;
        #1;
        chk("s0_rdy_comb", 32'(in_ready0), 32'd1);
        cyc();
        in_valid0 = 1'b0;
        @(negedge clk);
        chk("s0_capture", aluout_out0, 32'h62);
        chk("s0_valid2", 32'(out_valid0), 32'd1);
        cyc();
        @(negedge clk);
        chk("s0_empty", 32'(out_valid0), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
